// File: rtl/stack_pkg.sv
// Shared types for the operand-stack engine: command codes, FSM states, opcode width.
package stack_pkg;

  localparam int OPC_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP   = 3'd0,
    OP_PUSH  = 3'd1,
    OP_POP   = 3'd2,
    OP_DUP   = 3'd3,
    OP_SWAP  = 3'd4,
    OP_CLEAR = 3'd5
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SWAP2 = 1'b1
  } st_e;

endpackage

// File: rtl/stack_engine_if.sv
// Command/status bundle between the stack controller (master) and stack_engine (slave).
// The hwm status signal exists only when STACK_WATERMARK_EN is defined.
interface stack_engine_if
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             op_valid;
  logic             op_ready;
  logic [OPC_W-1:0] op_code;
  logic [WIDTH-1:0] op_data;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             done;
  logic             err_ovf;
  logic             err_unf;
  logic             err_clr;
`ifdef STACK_WATERMARK_EN
  logic [CW-1:0]    hwm;
`endif

  modport master (
    output op_valid, op_code, op_data, err_clr,
    input  op_ready, tos, nos, count, empty, full, done, err_ovf, err_unf
`ifdef STACK_WATERMARK_EN
    , input hwm
`endif
  );

  modport slave (
    input  op_valid, op_code, op_data, err_clr,
    output op_ready, tos, nos, count, empty, full, done, err_ovf, err_unf
`ifdef STACK_WATERMARK_EN
    , output hwm
`endif
  );

endinterface

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH stack storage: one synchronous write port, two asynchronous read ports.
module stack_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr0_i,
  input  logic [AW-1:0]    raddr1_i,
  output logic [WIDTH-1:0] rdata0_o,
  output logic [WIDTH-1:0] rdata1_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/stack_engine.sv
// Operand stack with op/valid/ready command port, DUP/SWAP/CLEAR, sticky error flags.
// Optional high-water-mark output when STACK_WATERMARK_EN is defined.
module stack_engine
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  stack_engine_if.slave        bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  st_e              state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] temp_q, temp_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ovf_set, unf_set;
  logic             we;
  logic [AW-1:0]    waddr, raddr0, raddr1;
  logic [WIDTH-1:0] wdata, rd0, rd1, tos, nos;
  logic             accept, is_empty, is_full;

  stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rf (
    .clk      (clk),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .raddr0_i (raddr0),
    .raddr1_i (raddr1),
    .rdata0_o (rd0),
    .rdata1_o (rd1)
  );

  // Read addresses wrap harmlessly when count<2; tos/nos are masked below.
  assign raddr0   = AW'(count_q - CW'(1));
  assign raddr1   = AW'(count_q - CW'(2));
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign tos      = is_empty ? '0 : rd0;
  assign nos      = (count_q < CW'(2)) ? '0 : rd1;
  assign accept   = bus.op_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    temp_d  = temp_q;
    done_d  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    we      = 1'b0;
    waddr   = AW'(count_q);
    wdata   = bus.op_data;
    case (state_q)
      IDLE: begin
        if (accept) begin
          done_d = 1'b1;
          case (op_e'(bus.op_code))
            OP_PUSH: begin
              if (is_full) ovf_set = 1'b1;
              else begin
                we      = 1'b1;
                count_d = count_q + CW'(1);
              end
            end
            OP_POP: begin
              if (is_empty) unf_set = 1'b1;
              else          count_d = count_q - CW'(1);
            end
            OP_DUP: begin
              if (is_empty)     unf_set = 1'b1;
              else if (is_full) ovf_set = 1'b1;
              else begin
                we      = 1'b1;
                wdata   = tos;
                count_d = count_q + CW'(1);
              end
            end
            OP_SWAP: begin
              if (count_q < CW'(2)) unf_set = 1'b1;
              else begin
                // Second half of the exchange happens in SWAP2; done waits for it.
                done_d  = 1'b0;
                temp_d  = tos;
                we      = 1'b1;
                waddr   = raddr0;
                wdata   = nos;
                state_d = SWAP2;
              end
            end
            OP_CLEAR: count_d = '0;
            default:  ;
          endcase
        end
      end
      SWAP2: begin
        we      = 1'b1;
        waddr   = raddr1;
        wdata   = temp_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ovf_d = bus.err_clr ? 1'b0 : (ovf_q | ovf_set);
    unf_d = bus.err_clr ? 1'b0 : (unf_q | unf_set);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    temp_q <= temp_d;
  end

`ifdef STACK_WATERMARK_EN
  logic [CW-1:0] hwm_q, hwm_d;

  // Tracks count_d so the mark moves in the same cycle as count; CLEAR drives count_d to 0.
  always_comb begin
    hwm_d = hwm_q;
    if (accept && (op_e'(bus.op_code) == OP_CLEAR)) hwm_d = '0;
    else if (count_d > hwm_q)                       hwm_d = count_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hwm_q <= '0;
    else      hwm_q <= hwm_d;
  end

  assign bus.hwm = hwm_q;
`endif

  assign bus.op_ready = (state_q == IDLE);
  assign bus.tos      = tos;
  assign bus.nos      = nos;
  assign bus.count    = count_q;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.done     = done_q;
  assign bus.err_ovf  = ovf_q;
  assign bus.err_unf  = unf_q;

endmodule

// File: tb/tb_stack_engine.sv
// Scoreboard bench for stack_engine: driver queues expected post-op state, monitor checks on done.
module tb_stack_engine;
  import stack_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  typedef struct {
    logic [3:0] cnt;
    logic [7:0] tos;
    logic [7:0] nos;
    logic       ovf;
    logic       unf;
    string      nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sbq[$];

  stack_engine_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bif ();

  stack_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] c, input logic [7:0] t, input logic [7:0] n,
                              input logic o, input logic u, input string nm);
    exp_t e;
    e.cnt = c; e.tos = t; e.nos = n; e.ovf = o; e.unf = u; e.nm = nm;
    return e;
  endfunction

  // Monitor: every done pulse consumes one expectation.
  always @(negedge clk) begin
    if (rst_n && bif.done === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.nm, ".count"}, 32'(bif.count), 32'(e.cnt));
        chk({e.nm, ".tos"},   32'(bif.tos),   32'(e.tos));
        chk({e.nm, ".nos"},   32'(bif.nos),   32'(e.nos));
        chk({e.nm, ".ovf"},   32'(bif.err_ovf), 32'(e.ovf));
        chk({e.nm, ".unf"},   32'(bif.err_unf), 32'(e.unf));
        chk({e.nm, ".empty"}, 32'(bif.empty), 32'(e.cnt == 4'd0));
        chk({e.nm, ".full"},  32'(bif.full),  32'(e.cnt == 4'(DEPTH)));
      end
    end
  end

  task automatic issue(input op_e op, input logic [7:0] d, input logic clr, input exp_t e);
    int w;
    w = 0;
    while (bif.op_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (bif.op_ready !== 1'b1) chk({e.nm, ".ready_timeout"}, 32'd0, 32'd1);
    bif.op_valid = 1'b1;
    bif.op_code  = op;
    bif.op_data  = d;
    bif.err_clr  = clr;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    bif.op_valid = 1'b0;
    bif.err_clr  = 1'b0;
    bif.op_code  = OP_NOP;
    @(negedge clk);
  endtask

  initial begin
    bif.op_valid = 1'b0;
    bif.op_code  = OP_NOP;
    bif.op_data  = '0;
    bif.err_clr  = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst.count", 32'(bif.count), 32'd0);
    chk("rst.ready", 32'(bif.op_ready), 32'd1);
    chk("rst.done",  32'(bif.done), 32'd0);
    chk("rst.empty", 32'(bif.empty), 32'd1);
    chk("rst.ovf",   32'(bif.err_ovf), 32'd0);
    chk("rst.unf",   32'(bif.err_unf), 32'd0);
    chk("rst.tos",   32'(bif.tos), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three pushes
    issue(OP_PUSH, 8'h11, 1'b0, mk(4'd1, 8'h11, 8'h00, 1'b0, 1'b0, "push11"));
    issue(OP_PUSH, 8'h22, 1'b0, mk(4'd2, 8'h22, 8'h11, 1'b0, 1'b0, "push22"));
    issue(OP_PUSH, 8'h33, 1'b0, mk(4'd3, 8'h33, 8'h22, 1'b0, 1'b0, "push33"));

    // SWAP: busy for one cycle, done one cycle later than single-cycle ops
    issue(OP_SWAP, 8'h00, 1'b0, mk(4'd3, 8'h22, 8'h33, 1'b0, 1'b0, "swap"));
    chk("swap.ready_low", 32'(bif.op_ready), 32'd0);
    chk("swap.done_not_yet", 32'(bif.done), 32'd0);
    @(negedge clk);
    chk("swap.ready_back", 32'(bif.op_ready), 32'd1);

    // Fill to DEPTH, then overflow on PUSH and DUP
    issue(OP_CLEAR, 8'h00, 1'b0, mk(4'd0, 8'h00, 8'h00, 1'b0, 1'b0, "clear1"));
    for (int i = 1; i <= DEPTH; i++)
      issue(OP_PUSH, 8'(i), 1'b0, mk(4'(i), 8'(i), 8'(i - 1), 1'b0, 1'b0, "fill"));
    issue(OP_PUSH, 8'hAA, 1'b0, mk(4'd8, 8'h08, 8'h07, 1'b1, 1'b0, "ovf_push"));
    issue(OP_DUP,  8'h00, 1'b0, mk(4'd8, 8'h08, 8'h07, 1'b1, 1'b0, "ovf_dup"));

    // Underflow and err_clr priority
    issue(OP_CLEAR, 8'h00, 1'b1, mk(4'd0, 8'h00, 8'h00, 1'b0, 1'b0, "clear2"));
    issue(OP_POP,   8'h00, 1'b0, mk(4'd0, 8'h00, 8'h00, 1'b0, 1'b1, "unf_pop"));
    issue(OP_POP,   8'h00, 1'b1, mk(4'd0, 8'h00, 8'h00, 1'b0, 1'b0, "unf_pop_clr"));

    // SWAP with one entry is rejected without a busy cycle; DUP then copies tos
    issue(OP_PUSH, 8'h5A, 1'b0, mk(4'd1, 8'h5A, 8'h00, 1'b0, 1'b0, "push5a"));
    issue(OP_SWAP, 8'h00, 1'b0, mk(4'd1, 8'h5A, 8'h00, 1'b0, 1'b1, "swap_unf"));
    chk("swap_unf.ready", 32'(bif.op_ready), 32'd1);
    issue(OP_DUP,  8'h00, 1'b0, mk(4'd2, 8'h5A, 8'h5A, 1'b0, 1'b1, "dup"));
    issue(OP_NOP,  8'h00, 1'b1, mk(4'd2, 8'h5A, 8'h5A, 1'b0, 1'b0, "nop_clr"));
    issue(OP_PUSH, 8'h77, 1'b0, mk(4'd3, 8'h77, 8'h5A, 1'b0, 1'b0, "push77"));
    chk("prepop.tos", 32'(bif.tos), 32'h77);
    issue(OP_POP,  8'h00, 1'b0, mk(4'd2, 8'h5A, 8'h5A, 1'b0, 1'b0, "pop"));
    issue(3'b110 == 3'b110 ? op_e'(3'b110) : OP_NOP, 8'h00, 1'b0,
          mk(4'd2, 8'h5A, 8'h5A, 1'b0, 1'b0, "reserved"));

    // Reset during SWAP2 abandons the swap
    bif.op_valid = 1'b1;
    bif.op_code  = OP_SWAP;
    @(posedge clk);
    #1;
    bif.op_valid = 1'b0;
    bif.op_code  = OP_NOP;
    @(negedge clk);
    chk("rstswap.busy", 32'(bif.op_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rstswap.ready", 32'(bif.op_ready), 32'd1);
    chk("rstswap.count", 32'(bif.count), 32'd0);
    chk("rstswap.done",  32'(bif.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Watermark sequence
    for (int i = 1; i <= 5; i++)
      issue(OP_PUSH, 8'(8'hA0 + i), 1'b0,
            mk(4'(i), 8'(8'hA0 + i), (i == 1) ? 8'h00 : 8'(8'hA0 + i - 1), 1'b0, 1'b0, "wm_push"));
    issue(OP_POP, 8'h00, 1'b0, mk(4'd4, 8'hA4, 8'hA3, 1'b0, 1'b0, "wm_pop1"));
    issue(OP_POP, 8'h00, 1'b0, mk(4'd3, 8'hA3, 8'hA2, 1'b0, 1'b0, "wm_pop2"));
`ifdef STACK_WATERMARK_EN
    chk("hwm.after_pops", 32'(bif.hwm), 32'd5);
`endif
    issue(OP_CLEAR, 8'h00, 1'b0, mk(4'd0, 8'h00, 8'h00, 1'b0, 1'b0, "wm_clear"));
`ifdef STACK_WATERMARK_EN
    chk("hwm.after_clear", 32'(bif.hwm), 32'd0);
`endif

    for (int w = 0; w < 10 && sbq.size() != 0; w++) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
